// File: rtl/score_bcd_accum_pkg.sv
// Shared event codes, BCD point values and FSM encoding for the score keeper.
// Pure definitions and helpers; no state.
package pacman_score_pkg;

  typedef enum logic [1:0] {
    EV_PELLET = 2'b00,
    EV_POWER  = 2'b01,
    EV_GHOST  = 2'b10,
    EV_FRUIT  = 2'b11
  } ev_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADD    = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam logic [15:0] PTS_PELLET     = 16'h0010;
  localparam logic [15:0] PTS_POWER      = 16'h0050;
  localparam logic [15:0] PTS_FRUIT      = 16'h0100;
  localparam logic [15:0] PTS_GHOST_BASE = 16'h0200;
  localparam logic [15:0] SCORE_MAX      = 16'h9999;

  // Ghost value is 200 << combo, kept pre-converted to BCD.
  function automatic logic [15:0] event_pts(ev_t ev, logic [1:0] combo);
    logic [15:0] pts;
    pts = PTS_PELLET;
    case (ev)
      EV_PELLET: pts = PTS_PELLET;
      EV_POWER:  pts = PTS_POWER;
      EV_FRUIT:  pts = PTS_FRUIT;
      EV_GHOST: begin
        case (combo)
          2'd0:    pts = PTS_GHOST_BASE;
          2'd1:    pts = 16'h0400;
          2'd2:    pts = 16'h0800;
          default: pts = 16'h1600;
        endcase
      end
      default:   pts = PTS_PELLET;
    endcase
    return pts;
  endfunction

  function automatic logic bcd_gt(logic [15:0] a, logic [15:0] b);
    for (int d = 3; d >= 0; d--) begin
      if (a[d*4 +: 4] > b[d*4 +: 4]) return 1'b1;
      if (a[d*4 +: 4] < b[d*4 +: 4]) return 1'b0;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/score_bcd_accum_if.sv
// Event handshake from gameCtl plus the score buses toward the seg display.
// master = gameCtl/display side, slave = score_bcd_accum.
interface score_bcd_accum_if;
  logic        clear;
  logic        event_valid;
  logic [1:0]  event_type;
  logic        event_ready;
  logic [15:0] score;
  logic        score_upd;
  logic [15:0] hi_score;

  modport master (
    output clear, event_valid, event_type,
    input  event_ready, score, score_upd, hi_score
  );

  modport slave (
    input  clear, event_valid, event_type,
    output event_ready, score, score_upd, hi_score
  );
endinterface

// File: rtl/score_bcd_accum_digit_add.sv
// Single BCD digit adder: a + b + cin, decimal-corrected. Purely combinational.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [4:0] raw;

  assign raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
  assign cout = (raw > 5'd9);
  assign sum  = cout ? 4'(raw - 5'd10) : raw[3:0];
endmodule

// File: rtl/score_bcd_accum.sv
// BCD score accumulator: accepts an event in IDLE, adds one digit per cycle, commits 5 edges later.
// event_ready is low while busy or while clear is asserted; high score register only with SCORE_HISCORE_EN.
module score_bcd_accum
  import pacman_score_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int COMBO_MAX = 3
) (
  input  logic                clk,
  input  logic                reset,
  score_bcd_accum_if.slave    bus
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(COMBO_MAX + 1);

  state_t          state;
  logic [W-1:0]    score_q;
  logic [W-1:0]    work_q;
  logic [W-1:0]    addend_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [CW-1:0]   combo_q;
  logic            upd_q;

  ev_t             ev;
  logic [3:0]      w_dig;
  logic [3:0]      a_dig;
  logic [3:0]      dig_sum;
  logic            dig_cout;
  logic [W-1:0]    commit_val;

  assign ev    = ev_t'(bus.event_type);
  assign w_dig = work_q[{idx_q, 2'b00} +: 4];
  assign a_dig = addend_q[{idx_q, 2'b00} +: 4];

  // One adder, walked across the digits LSD first.
  bcd_digit_add u_digit_add (
    .a    (w_dig),
    .b    (a_dig),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  // Carry out of the MSD, or an already-full score, pins the result at 9999.
  assign commit_val = (carry_q || score_q == SCORE_MAX) ? SCORE_MAX : work_q;

  assign bus.event_ready = (state == ST_IDLE) && !bus.clear;
  assign bus.score       = score_q;
  assign bus.score_upd   = upd_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      score_q  <= '0;
      work_q   <= '0;
      addend_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      combo_q  <= '0;
      upd_q    <= 1'b0;
    end else if (bus.clear) begin
      state   <= ST_IDLE;
      score_q <= '0;
      combo_q <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.event_valid) begin
            addend_q <= event_pts(ev, 2'(combo_q));
            work_q   <= score_q;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            state    <= ST_ADD;
            case (ev)
              EV_POWER: combo_q <= '0;
              EV_GHOST: if (int'(combo_q) < COMBO_MAX) combo_q <= combo_q + 1'b1;
              default:  ;
            endcase
          end
        end
        ST_ADD: begin
          work_q[{idx_q, 2'b00} +: 4] <= dig_sum;
          carry_q <= dig_cout;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == IW'(DIGITS - 1)) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          score_q <= commit_val;
          upd_q   <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SCORE_HISCORE_EN
  logic [W-1:0] hi_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= '0;
    end else if (!bus.clear && state == ST_COMMIT && bcd_gt(commit_val, hi_q)) begin
      hi_q <= commit_val;
    end
  end

  assign bus.hi_score = hi_q;
`else
  assign bus.hi_score = '0;
`endif

endmodule

// File: doc/score_bcd_accum.md
Name: score_bcd_accum

Overview:
- Score keeper that sits between gameCtl and the seg display driver.
- Accepts scoring events from gameCtl over a valid/ready handshake and converts each event to a BCD point value.
- Adds the value to a 4-digit packed-BCD score with a digit-serial adder, saturating at 9999.
- Drives the 16-bit disp_num bus of the seg display directly. Also tracks the ghost-eating combo multiplier.

Parameters:
- DIGITS, 4, number of BCD digits in the score. Fixed at 4 to match the seg display; the score is 4*DIGITS bits wide.
- COMBO_MAX, 3, maximum ghost combo index; the ghost value is 200 << combo.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  new-game pulse from gameCtl. Synchronous; zeroes the score and the combo.
- event_valid  input  1  a scoring event is offered.
- event_type  input  2  00=PELLET(10), 01=POWER(50), 10=GHOST(200<<combo), 11=FRUIT(100).
- event_ready  output  1  block can accept an event this cycle.
- score  output  16  packed BCD score; digit 3 is in [15:12]. Feeds seg disp_num.
- score_upd  output  1  one-cycle pulse when score is committed.
- hi_score  output  16  packed BCD high score (see Optional Feature).

Behaviour:
- Reset and clock:
  - One clock (clk). Reset is synchronous and active-high; reset is sampled only on the rising edge of clk.
  - Reset values: score=0x0000, hi_score=0x0000, score_upd=0, combo=0, FSM in IDLE. event_ready goes to 1 on the first cycle after reset deasserts.
- FSM states: IDLE, ADD, COMMIT.
  - IDLE: event_ready = !clear. A transfer occurs when event_valid && event_ready at a rising edge (E0).
    - At E0: latch the BCD addend, digit index := 0, carry := 0, working register := score, go to ADD.
  - ADD: one digit per cycle, at edges E1..E4. Digit sum = w[i] + a[i] + carry; if the sum > 9, subtract 10 and set carry=1. Digit index increments. After digit 3, go to COMMIT.
  - COMMIT (edge E5):
    - If carry out of digit 3 is 1, or score was already 0x9999, score := 0x9999 (saturate). Otherwise score := working register.
    - score_upd = 1 for the cycle following E5. Return to IDLE; event_ready is high again in the cycle after E5.
- Latency: new score is visible 5 edges after acceptance. Maximum throughput is one event per 6 cycles.
- event_ready is 0 in ADD and COMMIT. Upstream holds event_valid and event_type stable until the transfer.
- Addend table (BCD): PELLET 0x0010, POWER 0x0050, FRUIT 0x0100, GHOST 0x0200/0x0400/0x0800/0x1600 for combo 0..3.
- Combo counter, updated at acceptance (E0):
  - POWER: combo := 0.
  - GHOST: the addend uses the current combo; then combo := min(combo+1, COMBO_MAX).
  - PELLET and FRUIT: combo unchanged.
- clear:
  - Highest priority after reset. At the edge where clear=1: score := 0, combo := 0, any in-flight ADD/COMMIT is aborted with no score_upd, FSM := IDLE.
  - An event offered in the same cycle as clear is not accepted, because event_ready=0.
  - hi_score is not affected by clear.
- Reset mid-operation: the operation is aborted, and all state returns to its reset values at that edge.
- Once score is saturated, further events still handshake and pulse score_upd, but score stays 0x9999.

Optional Feature:
- Macro: SCORE_HISCORE_EN.
- Defined: at COMMIT, if the committed score > hi_score (compared as BCD, digit-wise from MSD), then hi_score := committed score. Same edge as the score commit. Cleared only by reset.
- Not defined: hi_score is tied to 0x0000 and no high-score register is synthesised.

Decomposition:
- Package pacman_score_pkg holds:
  - event_type codes: EV_PELLET, EV_POWER, EV_GHOST, EV_FRUIT.
  - BCD point constants: PTS_PELLET, PTS_POWER, PTS_FRUIT, PTS_GHOST_BASE.
  - FSM state encoding, plus SCORE_MAX = 16'h9999.
- One sub-module, bcd_digit_add: combinational 4-bit BCD digit + digit + carry-in, producing digit-out and carry-out. It is instanced once and time-multiplexed by the digit index.

Test Plan:
- Reset, then one PELLET event: event_ready=1 the cycle after reset deasserts. score=0x0010 exactly 5 edges after acceptance; score_upd high for one cycle.
- Combo: POWER, GHOST, GHOST, GHOST, GHOST, GHOST -> score 0x0050, 0x0250, 0x0650, 0x1450, 0x3050, 0x4650 (combo saturates at 1600). Then POWER, GHOST -> 0x4700, 0x4900.
- BCD carry: preload to 0x0990 with 99 pellets, then PELLET -> 0x1000. Checks the carry chain across 3 digits.
- Saturation: reach 0x9950, then GHOST (200) -> 0x9999. A further PELLET -> still 0x9999, with score_upd still pulsing.
- clear during ADD (accept at E0, clear at E2) -> score=0x0000 at E2, no score_upd, event_ready=1 the next cycle. An event offered together with clear sees event_ready=0.
- With SCORE_HISCORE_EN: score to 0x0150, clear, score to 0x0060 -> hi_score stays 0x0150; score to 0x0160 -> hi_score=0x0160. Without the macro, hi_score is always 0x0000.
